eth_txbuf_reader: RTL and testbench
===================================

Name: eth_txbuf_reader

Overview:
Frame-read engine on the narrow 16-bit port of the dual-port Ethernet buffer. The host writes frames through the 64-bit port. This block reads one frame out as 16-bit halfwords and serialises it into an 8-bit AXI-Stream toward the TX MAC, using a 2-word prefetch FIFO. One start command sends one frame and ends with a done pulse.

Parameters:
ADDR_W, 13, halfword address width of the buffer narrow port
LEN_W, 12, width of byte-length field; legal lengths 0..2^LEN_W-1

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
start  in  1  frame command; sampled only when busy=0
base_addr  in  ADDR_W  halfword address of first frame byte pair
byte_len  in  LEN_W  frame length in bytes
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at frame completion
mem_en  out  1  read enable to buffer narrow port
mem_addr  out  ADDR_W  read halfword address
mem_rdata  in  16  read data; valid in the cycle after mem_en=1
m_axis_tdata  out  8  stream byte
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  marks final byte of frame

Behaviour:
- Reset (async, any time, including mid-frame) forces outputs low:
  - busy=0, done=0, mem_en=0, mem_addr=0, tvalid=0, tlast=0, tdata=0.
  - FIFO, counters and FSM cleared to IDLE.
  - A partially sent frame is abandoned; no tlast is emitted.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 with byte_len>0: latch base_addr, byte_len; compute words=ceil(byte_len/2); go to RUN.
  - start=1 with byte_len=0: go to FIN, so done pulses in the next cycle with no beats and no reads.
  - start while busy=1 is ignored.
- RUN, read issue:
  - mem_en=1 in a cycle only when (reads_in_flight + fifo_count) < 2 and words remain to issue.
  - mem_en and mem_addr are registered outputs.
  - mem_addr increments by 1 per issued read, wrapping modulo 2^ADDR_W (base near top wraps to 0).
- RUN, capture: mem_rdata is written into the FIFO at the end of the cycle following a mem_en=1 cycle.
- RUN, serialise:
  - Each FIFO word yields byte [7:0] first, then [15:8].
  - For odd byte_len, the last word yields only [7:0]; [15:8] is discarded.
  - A word is popped after its last used byte handshakes.
- AXI-Stream rules:
  - tvalid is high whenever the FIFO holds an unsent byte.
  - tdata, tvalid and tlast stay stable while tvalid=1 and tready=0.
  - A handshake is tvalid&tready.
  - tlast=1 exactly on byte number byte_len-1.
- Latency: start in cycle 0 → mem_en cycle 1 → mem_rdata cycle 2 → first tvalid cycle 3.
- Throughput: sustained 1 byte/cycle with tready held high; no bubbles after the first byte.
- Backpressure: with tready low, at most 2 words are buffered and no further reads are issued. No data is lost or duplicated.
- FIN: entered in the cycle after the tlast handshake (or from IDLE when length is 0).
  - In FIN: done=1 and busy=0 for exactly one cycle.
  - Next state: IDLE.
  - A new start can be accepted in the cycle after done.
- Counters:
  - Byte counter is LEN_W bits.
  - Word-issue counter is LEN_W bits, so no overflow is possible for a legal byte_len.

Test Plan:
1. Reset, then start, base=0x0010, len=6, mem words 0x2211,0x4433,0x6655, tready=1 → mem_addr 0x10,0x11,0x12; bytes 11,22,33,44,55,66; tlast on 66; first tvalid in cycle 3; done pulses 1 cycle after the 66 handshake.
2. Odd length: len=3, words 0xBBAA,0xEECC → bytes AA,BB,CC with tlast on CC; EE never output; exactly 2 reads issued.
3. Backpressure: len=8 with tready toggled 1,0,0,1,… → tdata held stable while stalled; never more than 2 words buffered; no reads issued while full; all 8 bytes in order.
4. Wrap: base=0x1FFF, len=4 → mem_addr 0x1FFF then 0x0000; bytes correct.
5. len=0 start → done pulse in the following cycle; no mem_en and no tvalid. A start pulsed while busy → ignored, and the current frame completes unaltered.
6. Assert rst mid-frame with tvalid=1 → tvalid, busy and mem_en drop immediately. A new start with len=2 then runs cleanly with the correct first byte.

Source files
------------

// File: rtl/eth_txbuf_reader_if.sv
// Buffer narrow-port read bus and 8-bit AXI-Stream toward the TX MAC.
interface eth_txbuf_reader_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  mem_rdata, m_axis_tready
  );

  modport slave (
    input  mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output mem_rdata, m_axis_tready
  );
endinterface

// File: rtl/eth_txbuf_reader.sv
// Reads one frame from the Ethernet buffer narrow port as halfwords and
// serialises it low byte first into an 8-bit AXI-Stream, through a 2-word
// prefetch FIFO. One accepted start sends one frame and ends with done.
module eth_txbuf_reader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_len,
  output logic              busy,
  output logic              done,
  eth_txbuf_reader_if.master bus
);

  localparam int unsigned LW1 = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  sent_q;        // bytes handshaken so far
  logic [LEN_W-1:0]  issue_left_q;  // words still to be read
  logic [15:0]       fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              byte_hi_q;     // head word already gave its low byte
  logic              rd_pending_q;  // mem_rdata is valid this cycle

  logic              hs;
  logic              pop;
  logic              capture;
  logic [1:0]        count_n;
  logic              rd_ptr_n;
  logic              byte_hi_n;
  logic [LEN_W-1:0]  sent_n;
  logic [15:0]       head_n;
  logic              issue_n;
  logic [LEN_W-1:0]  words;

  // Next FIFO/stream state; the registered stream outputs are loaded from it.
  always_comb begin
    hs        = bus.m_axis_tvalid & bus.m_axis_tready;
    pop       = hs & (byte_hi_q | bus.m_axis_tlast);
    capture   = rd_pending_q;
    count_n   = count_q + 2'(capture) - 2'(pop);
    rd_ptr_n  = rd_ptr_q ^ pop;
    byte_hi_n = pop ? 1'b0 : (byte_hi_q | hs);
    sent_n    = sent_q + LEN_W'(hs);
    head_n    = (capture && (wr_ptr_q == rd_ptr_n)) ? bus.mem_rdata : fifo_q[rd_ptr_n];
    // Words held plus the read currently on the bus must stay below two.
    issue_n   = (issue_left_q != '0) && ((3'(count_n) + 3'(bus.mem_en)) < 3'd2);
    words     = LEN_W'(({1'b0, byte_len} + LW1'(1)) >> 1);
  end

  // Control FSM, read issue, prefetch FIFO and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.mem_en        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tdata  <= '0;
      len_q             <= '0;
      sent_q            <= '0;
      issue_left_q      <= '0;
      fifo_q[0]         <= '0;
      fifo_q[1]         <= '0;
      wr_ptr_q          <= 1'b0;
      rd_ptr_q          <= 1'b0;
      count_q           <= '0;
      byte_hi_q         <= 1'b0;
      rd_pending_q      <= 1'b0;
    end else begin
      done         <= 1'b0;
      rd_pending_q <= bus.mem_en;
      case (state)
        IDLE: begin
          busy              <= 1'b0;
          bus.mem_en        <= 1'b0;
          bus.m_axis_tvalid <= 1'b0;
          bus.m_axis_tlast  <= 1'b0;
          bus.m_axis_tdata  <= '0;
          count_q           <= '0;
          wr_ptr_q          <= 1'b0;
          rd_ptr_q          <= 1'b0;
          byte_hi_q         <= 1'b0;
          sent_q            <= '0;
          if (start) begin
            len_q <= byte_len;
            if (byte_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state        <= RUN;
              busy         <= 1'b1;
              bus.mem_en   <= 1'b1;
              bus.mem_addr <= base_addr;
              issue_left_q <= words - LEN_W'(1);
            end
          end
        end
        RUN: begin
          if (capture) begin
            fifo_q[wr_ptr_q] <= bus.mem_rdata;
          end
          wr_ptr_q   <= wr_ptr_q ^ capture;
          rd_ptr_q   <= rd_ptr_n;
          count_q    <= count_n;
          byte_hi_q  <= byte_hi_n;
          sent_q     <= sent_n;
          bus.mem_en <= issue_n;
          if (issue_n) begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            issue_left_q <= issue_left_q - LEN_W'(1);
          end
          bus.m_axis_tvalid <= (count_n != 2'd0);
          bus.m_axis_tdata  <= byte_hi_n ? head_n[15:8] : head_n[7:0];
          bus.m_axis_tlast  <= (count_n != 2'd0) && (sent_n == (len_q - LEN_W'(1)));
          if (hs && bus.m_axis_tlast) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state             <= IDLE;
          busy              <= 1'b0;
          bus.m_axis_tvalid <= 1'b0;
          bus.m_axis_tlast  <= 1'b0;
          bus.m_axis_tdata  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_txbuf_reader.sv
// Scoreboard bench for eth_txbuf_reader: a driver pushes the expected reads,
// bytes and frame timing; a negedge monitor pops and compares.
module tb_eth_txbuf_reader;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic              busy;
  logic              done;

  eth_txbuf_reader_if #(.ADDR_W(ADDR_W)) bus ();

  eth_txbuf_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       word_end;
  } beat_t;

  typedef struct {
    int start_cyc;
    int len;
  } frame_t;

  logic [15:0]       mem [MEM_DEPTH];
  beat_t             exp_beats [$];
  logic [ADDR_W-1:0] exp_addrs [$];
  frame_t            frames [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tready_mode = 0;

  // Buffer narrow port: one-cycle read latency, junk when not enabled.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_en ? mem[bus.mem_addr] : 16'($urandom);
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Reference model: a frame is the halfwords base..base+ceil(len/2)-1
  // (address wraps), each giving its low byte then its high byte, truncated to len.
  function automatic void push_frame(input logic [ADDR_W-1:0] b, input int len);
    frame_t f;
    beat_t  bt;
    logic [15:0] w;
    for (int i = 0; i < (len + 1) / 2; i++) exp_addrs.push_back(ADDR_W'(b + i));
    for (int i = 0; i < len; i++) begin
      w           = mem[ADDR_W'(b + i / 2)];
      bt.data     = (i % 2 == 0) ? w[7:0] : w[15:8];
      bt.last     = (i == len - 1);
      bt.word_end = (i % 2 == 1) || bt.last;
      exp_beats.push_back(bt);
    end
    f.start_cyc = cyc;
    f.len       = len;
    frames.push_back(f);
  endfunction

  // tready patterns: always high, random, or 1,0,0 repeating.
  initial begin
    int ph;
    ph = 0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = 1'($urandom % 2);
        default: begin
          bus.m_axis_tready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  // Monitor: compares reads, beats, stall stability, latency and done timing.
  int          outstanding;
  bit          saw_read;
  bit          saw_valid;
  bit          stalled_prev;
  logic [7:0]  held_data;
  logic        held_last;
  int          last_hs_cyc;

  always @(negedge clk) begin
    if (rst) begin
      outstanding  = 0;
      saw_read     = 1'b0;
      saw_valid    = 1'b0;
      stalled_prev = 1'b0;
      last_hs_cyc  = 0;
    end else begin
      if (bus.mem_en) begin
        if (exp_addrs.size() == 0) flag("unexpected_mem_en");
        else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addrs.pop_front()));
        if (!saw_read && frames.size() > 0) begin
          chk("first_read_cycle", cyc, frames[0].start_cyc + 1);
          saw_read = 1'b1;
        end
        outstanding++;
        chk("buffered_words_le_2", 32'(outstanding <= 2), 32'd1);
      end
      if (bus.m_axis_tvalid) begin
        if (exp_beats.size() == 0) flag("unexpected_tvalid");
        if (!saw_valid && frames.size() > 0) begin
          chk("first_tvalid_cycle", cyc, frames[0].start_cyc + 3);
          saw_valid = 1'b1;
        end
        if (stalled_prev) begin
          chk("stall_tdata_stable", 32'(bus.m_axis_tdata), 32'(held_data));
          chk("stall_tlast_stable", 32'(bus.m_axis_tlast), 32'(held_last));
        end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready && exp_beats.size() > 0) begin
        beat_t b;
        b = exp_beats.pop_front();
        chk("tdata", 32'(bus.m_axis_tdata), 32'(b.data));
        chk("tlast", 32'(bus.m_axis_tlast), 32'(b.last));
        if (b.word_end) outstanding--;
        if (b.last) last_hs_cyc = cyc;
      end
      stalled_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      held_data    = bus.m_axis_tdata;
      held_last    = bus.m_axis_tlast;
      if (done) begin
        if (frames.size() == 0) flag("unexpected_done");
        else begin
          frame_t f;
          f = frames.pop_front();
          chk("done_cycle", cyc, (f.len == 0) ? f.start_cyc + 1 : last_hs_cyc + 1);
          chk("busy_low_at_done", 32'(busy), 32'd0);
        end
        saw_read  = 1'b0;
        saw_valid = 1'b0;
      end
    end
  end

  task automatic start_frame(input logic [ADDR_W-1:0] b, input int len);
    @(posedge clk);
    #1;
    base_addr = b;
    byte_len  = LEN_W'(len);
    start     = 1'b1;
    push_frame(b, len);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'(len > 0));
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("rst_tlast",  32'(bus.m_axis_tlast), 0);
    chk("rst_tdata",  32'(bus.m_axis_tdata), 0);
    rst = 1'b0;

    // Basic six-byte frame
    mem[13'h0010] = 16'h2211;
    mem[13'h0011] = 16'h4433;
    mem[13'h0012] = 16'h6655;
    tready_mode = 0;
    start_frame(13'h0010, 6);
    wait_done(100);

    // Odd length drops the final high byte
    mem[13'h0100] = 16'hBBAA;
    mem[13'h0101] = 16'hEECC;
    start_frame(13'h0100, 3);
    wait_done(100);

    // Backpressure 1,0,0 pattern
    tready_mode = 2;
    start_frame(13'h0200, 8);
    wait_done(200);

    // Address wrap at top of buffer
    tready_mode = 0;
    start_frame(13'h1FFF, 4);
    wait_done(100);

    // Zero length, then a start pulsed while busy is ignored
    start_frame(13'h0300, 0);
    wait_done(10);
    tready_mode = 1;
    start_frame(13'h0400, 10);
    @(posedge clk);
    #1;
    base_addr = 13'h0555;
    byte_len  = 12'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // Reset mid-frame with tvalid high, then a clean two-byte frame
    tready_mode = 0;
    start_frame(13'h0600, 20);
    begin
      int n;
      n = 0;
      while (bus.m_axis_tvalid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("tvalid_before_reset", 32'(bus.m_axis_tvalid), 1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("midrst_busy",   32'(busy), 0);
    chk("midrst_mem_en", 32'(bus.mem_en), 0);
    exp_beats.delete();
    exp_addrs.delete();
    frames.delete();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    start_frame(13'h0700, 2);
    wait_done(50);

    // Randomized frames
    repeat (25) begin
      int len;
      logic [ADDR_W-1:0] b;
      tready_mode = int'($urandom % 3);
      len = ($urandom % 8 == 0) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 40));
      b   = ADDR_W'($urandom);
      for (int i = 0; i < 4; i++) mem[ADDR_W'(b + i)] = 16'($urandom);
      start_frame(b, len);
      wait_done(4 * len + 50);
    end

    repeat (5) @(negedge clk);
    chk("beats_left",  32'(exp_beats.size()), 0);
    chk("reads_left",  32'(exp_addrs.size()), 0);
    chk("frames_left", 32'(frames.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
